// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller: timed NS/EW phases with all-red clearance,
// a latched pedestrian walk phase and a night flash mode.
module traffic_light_ctrl #(
   parameter int unsigned GREEN_CYCLES  = 8,
   parameter int unsigned YELLOW_CYCLES = 3,
   parameter int unsigned ALLRED_CYCLES = 2,
   parameter int unsigned WALK_CYCLES   = 6,
   parameter int unsigned FLASH_HALF    = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ped_req,
   input  logic       flash_mode,
   output logic [1:0] ns_light,
   output logic [1:0] ew_light,
   output logic       walk,
   output logic       ped_pending,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      st_allred2  = 3'd0,
      st_nsgreen  = 3'd1,
      st_nsyellow = 3'd2,
      st_allred1  = 3'd3,
      st_ewgreen  = 3'd4,
      st_ewyellow = 3'd5,
      st_pedwalk  = 3'd6,
      st_flash    = 3'd7
   } state_e;

   localparam logic [1:0] lt_red    = 2'b00;
   localparam logic [1:0] lt_green  = 2'b01;
   localparam logic [1:0] lt_yellow = 2'b10;
   localparam logic [1:0] lt_off    = 2'b11;

   localparam logic [CNT_W-1:0] green_ld  = CNT_W'(GREEN_CYCLES - 1);
   localparam logic [CNT_W-1:0] yellow_ld = CNT_W'(YELLOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] allred_ld = CNT_W'(ALLRED_CYCLES - 1);
   localparam logic [CNT_W-1:0] walk_ld   = CNT_W'(WALK_CYCLES - 1);
   localparam logic [CNT_W-1:0] flash_ld  = CNT_W'(FLASH_HALF - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             blink_q, blink_d;
   logic             ped_q, ped_d;
   logic             expired;

   assign expired     = (timer_q == '0);
   assign ped_pending = ped_q;
   assign state_o     = state_q;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q - 1'b1;
      blink_d = blink_q;
      ped_d   = ped_q;
      case (state_q)
         st_allred2: begin
            if (expired) begin
               if (flash_mode) begin
                  state_d = st_flash;
                  timer_d = flash_ld;
                  blink_d = 1'b1;
               end else if (ped_q) begin
                  state_d = st_pedwalk;
                  timer_d = walk_ld;
               end else begin
                  state_d = st_nsgreen;
                  timer_d = green_ld;
               end
            end
         end
         st_nsgreen: if (expired) begin
            state_d = st_nsyellow;
            timer_d = yellow_ld;
         end
         st_nsyellow: if (expired) begin
            state_d = st_allred1;
            timer_d = allred_ld;
         end
         st_allred1: begin
            if (expired) begin
               if (flash_mode) begin
                  state_d = st_flash;
                  timer_d = flash_ld;
                  blink_d = 1'b1;
               end else begin
                  state_d = st_ewgreen;
                  timer_d = green_ld;
               end
            end
         end
         st_ewgreen: if (expired) begin
            state_d = st_ewyellow;
            timer_d = yellow_ld;
         end
         st_ewyellow: if (expired) begin
            state_d = st_allred2;
            timer_d = allred_ld;
         end
         st_pedwalk: if (expired) begin
            state_d = st_nsgreen;
            timer_d = green_ld;
         end
         st_flash: begin
            // Timer counts half-periods; leave only after a dark half completes.
            if (expired) begin
               if (!blink_q && !flash_mode) begin
                  state_d = st_allred2;
                  timer_d = allred_ld;
                  blink_d = 1'b1;
               end else begin
                  blink_d = ~blink_q;
                  timer_d = flash_ld;
               end
            end
         end
         default: begin
            state_d = st_allred2;
            timer_d = allred_ld;
            blink_d = 1'b1;
         end
      endcase

      if (state_d == st_pedwalk && state_q != st_pedwalk) begin
         ped_d = 1'b0;
      end else if (state_q != st_pedwalk && ped_req) begin
         ped_d = 1'b1;
      end
   end

   function automatic logic [4:0] decode(input state_e st, input logic blink);
      logic [4:0] r;
      r = {lt_red, lt_red, 1'b0};
      case (st)
         st_nsgreen:  r = {lt_green, lt_red, 1'b0};
         st_nsyellow: r = {lt_yellow, lt_red, 1'b0};
         st_ewgreen:  r = {lt_red, lt_green, 1'b0};
         st_ewyellow: r = {lt_red, lt_yellow, 1'b0};
         st_pedwalk:  r = {lt_red, lt_red, 1'b1};
         st_flash:    r = blink ? {lt_yellow, lt_yellow, 1'b0} : {lt_off, lt_off, 1'b0};
         default:     r = {lt_red, lt_red, 1'b0};
      endcase
      return r;
   endfunction

   // Outputs are decoded from the next state so they change on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= st_allred2;
         timer_q  <= allred_ld;
         blink_q  <= 1'b1;
         ped_q    <= 1'b0;
         ns_light <= lt_red;
         ew_light <= lt_red;
         walk     <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         blink_q  <= blink_d;
         ped_q    <= ped_d;
         {ns_light, ew_light, walk} <= decode(state_d, blink_d);
      end
   end

endmodule
